wtu_arbiter: RTL and testbench

//  Shares one wtu_top instance among NCH input sample FIFOs, one frame (2**DEPTH samples) at a time.
//  - Grants a channel by round-robin and steers that channel's FIFO handshake into the WTU load port.
//  - Counts the WIDTH load beats and the WIDTH output beats of the frame.
//  - Tags each output write with {channel, per-channel frame index, WTU output address}.
//  - Sits between the channel FIFOs and wtu_top, and between wtu_top and the result memory.

---
 rtl/wtu_arbiter.sv | 139 +++++++++++++
 tb/tb_wtu_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wtu_arbiter.sv
// Round-robin arbiter that time-shares one wtu_top among NCH sample FIFOs, one frame at a time,
// and tags every transform output with {channel, per-channel frame index, WTU address}.
module wtu_arbiter #(
  parameter int BITWIDTH = 24,
  parameter int DEPTH    = 3,
  parameter int NCH      = 4,
  parameter int FRAME_BW = 4,
  localparam int CH_BW   = $clog2(NCH),
  localparam int WIDTH   = 2 ** DEPTH,
  localparam int AW      = CH_BW + FRAME_BW + DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NCH-1:0]          ch_ready,
  output logic [NCH-1:0]          ch_rd_en,
  input  logic [NCH*BITWIDTH-1:0] ch_data,
  output logic                    wtu_fifo_ready,
  input  logic                    wtu_fifo_rd_en,
  output logic [BITWIDTH-1:0]     wtu_fifo_data,
  input  logic                    wtu_mem_write,
  input  logic [DEPTH-1:0]        wtu_mem_addr,
  input  logic [BITWIDTH-1:0]     wtu_mem_data,
  input  logic                    mem_ready,
  output logic                    wtu_mem_ready,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [BITWIDTH-1:0]     mem_data,
  output logic                    busy,
  output logic [CH_BW-1:0]        cur_ch,
  output logic                    frame_done
);

  // Handshake: a load beat is any LOAD cycle with wtu_fifo_rd_en=1 (the WTU only pops while
  // wtu_fifo_ready=1); an output beat is any XFORM cycle with wtu_mem_write=1.
  typedef enum logic [1:0] {IDLE, LOAD, XFORM} state_t;

  state_t              state, state_next;
  logic [DEPTH:0]      beat_cnt;
  logic [CH_BW-1:0]    rr_ptr;
  logic [FRAME_BW-1:0] frame_cnt [NCH];
  logic                grant_valid;
  logic [CH_BW-1:0]    grant_ch;
  logic [2*NCH-1:0]    ready2;
  logic                load_beat, out_beat, last_beat;

  assign ready2    = {ch_ready, ch_ready};
  assign last_beat = (beat_cnt == (DEPTH + 1)'(WIDTH - 1));

  // Descending scan so the channel closest to rr_ptr is the one left standing.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ready2[int'(rr_ptr) + i]) begin
        grant_valid = 1'b1;
        grant_ch    = (int'(rr_ptr) + i >= NCH) ? CH_BW'(int'(rr_ptr) + i - NCH)
                                                : CH_BW'(int'(rr_ptr) + i);
      end
    end
  end

  always_comb begin
    state_next     = state;
    wtu_fifo_ready = 1'b0;
    wtu_fifo_data  = '0;
    ch_rd_en       = '0;
    mem_we         = 1'b0;
    frame_done     = 1'b0;
    load_beat      = 1'b0;
    out_beat       = 1'b0;
    case (state)
      IDLE: begin
        if (en && grant_valid) state_next = LOAD;
      end
      LOAD: begin
        wtu_fifo_ready   = ch_ready[cur_ch];
        wtu_fifo_data    = ch_data[cur_ch*BITWIDTH +: BITWIDTH];
        ch_rd_en[cur_ch] = wtu_fifo_rd_en;
        load_beat        = wtu_fifo_rd_en;
        if (load_beat && last_beat) state_next = XFORM;
      end
      XFORM: begin
        out_beat   = wtu_mem_write;
        mem_we     = out_beat;
        frame_done = out_beat && last_beat;
        if (frame_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cur_ch   <= '0;
      beat_cnt <= '0;
      for (int c = 0; c < NCH; c++) frame_cnt[c] <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (en && grant_valid) begin
            cur_ch   <= grant_ch;
            beat_cnt <= '0;
          end
        end
        LOAD: begin
          if (load_beat) beat_cnt <= last_beat ? '0 : beat_cnt + (DEPTH + 1)'(1);
        end
        XFORM: begin
          if (out_beat) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + (DEPTH + 1)'(1);
            if (last_beat) begin
              frame_cnt[cur_ch] <= frame_cnt[cur_ch] + FRAME_BW'(1);
              rr_ptr            <= (cur_ch == CH_BW'(NCH - 1)) ? '0 : cur_ch + CH_BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign wtu_mem_ready = mem_ready;
  assign mem_data      = wtu_mem_data;
  assign mem_addr      = {cur_ch, frame_cnt[cur_ch], wtu_mem_addr};

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && state == LOAD && wtu_fifo_rd_en)
      assert (ch_ready[cur_ch])
      else $error("wtu_arbiter: WTU popped empty channel %0d", cur_ch);
  end
`endif

endmodule

// File: tb/tb_wtu_arbiter.sv
// Directed bench for wtu_arbiter: a table of frames with hand-computed grants and frame indices,
// a WTU stand-in driven from tasks, and a write scoreboard fed by an expected queue.
module tb_wtu_arbiter;
  localparam int BW    = 24;
  localparam int DEPTH = 3;
  localparam int NCH   = 4;
  localparam int FBW   = 4;
  localparam int CH_BW = 2;
  localparam int AW    = CH_BW + FBW + DEPTH;
  localparam int WIDTH = 8;

  localparam int OPT_TOGGLE  = 1;
  localparam int OPT_NOISE   = 2;
  localparam int OPT_STALL   = 4;
  localparam int OPT_EN_DROP = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [NCH-1:0]    ch_ready = '0;
  logic [NCH-1:0]    ch_rd_en;
  logic [NCH*BW-1:0] ch_data = '0;
  logic              wtu_fifo_ready;
  logic              wtu_fifo_rd_en = 1'b0;
  logic [BW-1:0]     wtu_fifo_data;
  logic              wtu_mem_write = 1'b0;
  logic [DEPTH-1:0]  wtu_mem_addr = '0;
  logic [BW-1:0]     wtu_mem_data = '0;
  logic              mem_ready = 1'b0;
  logic              wtu_mem_ready;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [BW-1:0]     mem_data;
  logic              busy;
  logic [CH_BW-1:0]  cur_ch;
  logic              frame_done;

  wtu_arbiter #(.BITWIDTH(BW), .DEPTH(DEPTH), .NCH(NCH), .FRAME_BW(FBW)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_ready(ch_ready), .ch_rd_en(ch_rd_en), .ch_data(ch_data),
    .wtu_fifo_ready(wtu_fifo_ready), .wtu_fifo_rd_en(wtu_fifo_rd_en), .wtu_fifo_data(wtu_fifo_data),
    .wtu_mem_write(wtu_mem_write), .wtu_mem_addr(wtu_mem_addr), .wtu_mem_data(wtu_mem_data),
    .mem_ready(mem_ready), .wtu_mem_ready(wtu_mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .cur_ch(cur_ch), .frame_done(frame_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pop_cnt [NCH] = '{default: 0};
  int pop_total = 0;
  int fd_cnt    = 0;
  logic [BW-1:0]    lane [NCH];
  logic [AW+BW-1:0] exp_q [$];
  logic [AW+BW-1:0] exp_w;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // scoreboard: every mem_we must match the next expected {addr, data}
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) if (ch_rd_en[c]) begin pop_cnt[c]++; pop_total++; end
      if (frame_done) fd_cnt++;
      if (mem_we) begin
        if (exp_q.size() == 0) check("sb_extra_write", 64'({mem_addr, mem_data}), 64'(0));
        else begin
          exp_w = exp_q.pop_front();
          check("sb_write", 64'({mem_addr, mem_data}), 64'(exp_w));
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_lanes();
    for (int c = 0; c < NCH; c++) begin
      lane[c] = BW'($urandom);
      ch_data[c*BW +: BW] = lane[c];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ch_ready = '0; wtu_fifo_rd_en = 1'b0; wtu_mem_write = 1'b0;
    step();
    step();
    rst = 1'b0; en = 1'b1; mem_ready = 1'b1;
  endtask

  typedef struct {
    logic           rst_before;
    logic [NCH-1:0] mask;
    int             ch;
    int             frame;
    int             opts;
  } vec_t;

  task automatic run_frame(input vec_t v);
    int p0, t0, f0, beats, cyc;
    logic rdy;
    logic [BW-1:0] d;
    // IDLE cycle: the grant is taken at the next edge
    en = 1'b1; ch_ready = v.mask; wtu_fifo_rd_en = 1'b0;
    wtu_mem_write = ((v.opts & OPT_NOISE) != 0);
    new_lanes();
    #3;
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_mem_we", 64'(mem_we), 64'(0));
    p0 = pop_cnt[v.ch]; t0 = pop_total; f0 = fd_cnt;
    step();
    check("grant_busy", 64'(busy), 64'(1));
    check("grant_ch", 64'(cur_ch), 64'(v.ch));
    beats = 0; cyc = 0;
    while (beats < WIDTH) begin
      rdy = ((v.opts & OPT_TOGGLE) != 0) ? ((cyc / 3) % 2 == 0) : 1'b1;
      ch_ready = v.mask;
      ch_ready[v.ch] = rdy;
      new_lanes();
      wtu_fifo_rd_en = rdy;
      wtu_mem_write  = ((v.opts & OPT_NOISE) != 0) && (cyc % 2 == 1);
      if (((v.opts & OPT_EN_DROP) != 0) && beats == 3) en = 1'b0;
      #3;
      check("ld_fifo_ready", 64'(wtu_fifo_ready), 64'(rdy));
      check("ld_fifo_data", 64'(wtu_fifo_data), 64'(lane[v.ch]));
      check("ld_rd_en", 64'(ch_rd_en), rdy ? (64'(1) << v.ch) : 64'(0));
      check("ld_mem_we", 64'(mem_we), 64'(0));
      check("ld_cur_ch", 64'(cur_ch), 64'(v.ch));
      if (rdy) beats++;
      cyc++;
      step();
    end
    // first XFORM cycle: a stray pop request must not reach any channel
    ch_ready = v.mask; wtu_fifo_rd_en = 1'b1; wtu_mem_write = 1'b0;
    #3;
    check("xf_fifo_ready", 64'(wtu_fifo_ready), 64'(0));
    check("xf_fifo_data", 64'(wtu_fifo_data), 64'(0));
    check("xf_rd_en", 64'(ch_rd_en), 64'(0));
    check("xf_busy", 64'(busy), 64'(1));
    step();
    wtu_fifo_rd_en = 1'b0;
    if ((v.opts & OPT_STALL) != 0) begin
      mem_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
        #3;
        check("stall_wtu_mem_ready", 64'(wtu_mem_ready), 64'(0));
        check("stall_busy", 64'(busy), 64'(1));
        check("stall_frame_done", 64'(frame_done), 64'(0));
        step();
      end
      mem_ready = 1'b1;
    end
    for (int k = 0; k < WIDTH; k++) begin
      d = BW'($urandom);
      wtu_mem_write = 1'b1; wtu_mem_addr = DEPTH'(k); wtu_mem_data = d;
      exp_q.push_back({CH_BW'(v.ch), FBW'(v.frame), DEPTH'(k), d});
      #3;
      check("wr_mem_we", 64'(mem_we), 64'(1));
      check("wr_wtu_mem_ready", 64'(wtu_mem_ready), 64'(1));
      check("wr_frame_done", 64'(frame_done), 64'(k == WIDTH - 1));
      step();
    end
    wtu_mem_write = 1'b0;
    check("frame_pops_ch", 64'(pop_cnt[v.ch] - p0), 64'(WIDTH));
    check("frame_pops_all", 64'(pop_total - t0), 64'(WIDTH));
    check("frame_done_pulses", 64'(fd_cnt - f0), 64'(1));
  endtask

  vec_t vecs [9];
  vec_t v;

  initial begin
    // frames with hand-computed grant and frame index (rr pointer carried from previous row)
    vecs[0] = '{1'b0, 4'b0100, 2, 0, 0};
    vecs[1] = '{1'b1, 4'b1111, 0, 0, 0};
    vecs[2] = '{1'b0, 4'b1111, 1, 0, 0};
    vecs[3] = '{1'b0, 4'b1111, 2, 0, 0};
    vecs[4] = '{1'b0, 4'b1111, 3, 0, 0};
    vecs[5] = '{1'b0, 4'b1111, 0, 1, 0};
    vecs[6] = '{1'b0, 4'b1111, 1, 1, OPT_TOGGLE};
    vecs[7] = '{1'b0, 4'b1000, 3, 1, OPT_NOISE | OPT_STALL};
    vecs[8] = '{1'b0, 4'b1111, 0, 2, OPT_EN_DROP};

    rst = 1'b1;
    step();
    step();
    #3;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cur_ch", 64'(cur_ch), 64'(0));
    check("rst_rd_en", 64'(ch_rd_en), 64'(0));
    check("rst_fifo_ready", 64'(wtu_fifo_ready), 64'(0));
    check("rst_fifo_data", 64'(wtu_fifo_data), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_wtu_mem_ready", 64'(wtu_mem_ready), 64'(0));
    step();
    rst = 1'b0; en = 1'b1; mem_ready = 1'b1;
    #3;
    check("mem_ready_fwd", 64'(wtu_mem_ready), 64'(1));
    step();

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst_before) do_reset();
      run_frame(vecs[i]);
    end

    // en was dropped mid-frame: IDLE must hold although every channel is ready
    ch_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #3;
      check("en_off_busy", 64'(busy), 64'(0));
      check("en_off_rd_en", 64'(ch_rd_en), 64'(0));
      step();
    end
    en = 1'b1;
    ch_ready = 4'b0100;
    step();
    check("pre_rst_grant", 64'(cur_ch), 64'(2));
    for (int b = 0; b < 4; b++) begin
      wtu_fifo_rd_en = 1'b1;
      step();
    end
    // reset mid-load
    rst = 1'b1; ch_ready = '0;
    step();
    #3;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_rd_en", 64'(ch_rd_en), 64'(0));
    check("midrst_frame_done", 64'(frame_done), 64'(0));
    rst = 1'b0; wtu_fifo_rd_en = 1'b0;
    step();
    v = '{1'b0, 4'b1111, 0, 0, 0};
    run_frame(v);
    // ch3 frame counter starts from 0 again and wraps after 16 frames
    for (int i = 0; i < 17; i++) begin
      v = '{1'b0, 4'b1000, 3, i % 16, 0};
      run_frame(v);
    end
    step();
    check("sb_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
